// File: rtl/isdu_mc.sv
// Multi-cycle LC-3 instruction sequence/decode unit for the SLC-3 datapath.
// Moore-style control decode per state, with a shared wait counter for SRAM strobes.
module isdu_mc #(
  parameter int MEM_WAIT = 2,
  parameter bit PAUSE_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic       Stop,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Instr_done,
  output logic       Halted_o
);

  typedef enum logic [4:0] {
    S_HALTED, S_F18, S_F33, S_F35, S_D32,
    S_ADD, S_AND, S_NOT, S_BR0, S_BR22, S_JMP,
    S_JSR4, S_JSR21, S_LDR6, S_LDR25, S_LDR27,
    S_STR7, S_STR23, S_STR16, S_PAUSE1, S_PAUSE2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       wait_last;
  logic       fin;

  function automatic logic is_mem(input state_t s);
    return (s == S_F33) || (s == S_LDR25) || (s == S_STR16);
  endfunction

  assign wait_last = (wait_cnt == 4'd0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_HALTED;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (is_mem(state_nxt) && (state_nxt != state))
        wait_cnt <= WAIT_INIT;
      else if (is_mem(state) && !wait_last)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

  always_comb begin
    state_nxt  = state;
    fin        = 1'b0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Instr_done = 1'b0;
    Halted_o   = 1'b0;

    unique case (state)
      S_HALTED: begin
        Halted_o = 1'b1;
        if (Run) state_nxt = S_F18;
      end
      S_F18: begin
        GatePC    = 1'b1;
        LD_MAR    = 1'b1;
        LD_PC     = 1'b1;
        state_nxt = S_F33;
      end
      S_F33: begin
        Mem_OE = 1'b0;
        if (wait_last) begin
          LD_MDR    = 1'b1;
          state_nxt = S_F35;
        end
      end
      S_F35: begin
        GateMDR   = 1'b1;
        LD_IR     = 1'b1;
        state_nxt = S_D32;
      end
      S_D32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001: state_nxt = S_ADD;
          4'b0101: state_nxt = S_AND;
          4'b1001: state_nxt = S_NOT;
          4'b0000: state_nxt = S_BR0;
          4'b1100: state_nxt = S_JMP;
          4'b0100: state_nxt = S_JSR4;
          4'b0110: state_nxt = S_LDR6;
          4'b0111: state_nxt = S_STR7;
          4'b1101: if (PAUSE_EN) state_nxt = S_PAUSE1; else fin = 1'b1;
          default: fin = 1'b1;
        endcase
      end
      S_ADD, S_AND: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state == S_AND) ? 2'b01 : 2'b00;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        fin     = 1'b1;
      end
      S_NOT: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b10;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        fin     = 1'b1;
      end
      S_BR0: begin
        // BEN=0 makes this state the last cycle of the branch
        if (BEN) state_nxt = S_BR22;
        else     fin = 1'b1;
      end
      S_BR22: begin
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
        fin      = 1'b1;
      end
      S_JMP: begin
        ADDR1MUX = 1'b1;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
        fin      = 1'b1;
      end
      S_JSR4: begin
        GatePC    = 1'b1;
        DRMUX     = 1'b1;
        LD_REG    = 1'b1;
        state_nxt = S_JSR21;
      end
      S_JSR21: begin
        ADDR1MUX = ~IR_11;
        ADDR2MUX = IR_11 ? 2'b11 : 2'b00;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
        fin      = 1'b1;
      end
      S_LDR6, S_STR7: begin
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        state_nxt  = (state == S_LDR6) ? S_LDR25 : S_STR23;
      end
      S_LDR25: begin
        Mem_OE = 1'b0;
        if (wait_last) begin
          LD_MDR    = 1'b1;
          state_nxt = S_LDR27;
        end
      end
      S_LDR27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        fin     = 1'b1;
      end
      S_STR23: begin
        ALUK      = 2'b11;
        GateALU   = 1'b1;
        LD_MDR    = 1'b1;
        state_nxt = S_STR16;
      end
      S_STR16: begin
        Mem_WE = 1'b0;
        if (wait_last) fin = 1'b1;
      end
      S_PAUSE1: begin
        LD_LED = 1'b1;
        if (Continue) state_nxt = S_PAUSE2;
      end
      S_PAUSE2: begin
        if (!Continue) fin = 1'b1;
      end
      default: state_nxt = S_HALTED;
    endcase

    // Stop is only honoured on an instruction boundary
    if (fin) begin
      Instr_done = 1'b1;
      state_nxt  = Stop ? S_HALTED : S_F18;
    end
  end

endmodule
